// File: rtl/addsub_pipe_n_bit.sv
// addsub_pipe_n_bit
// Pipelined two's-complement add/subtract unit. The carry chain is cut into
// num_stages equal slices and one slice is resolved per clock. Each beat
// carries its resolved low result slices and its still-unprocessed high
// operand slices forward. The result and flags are registered in the final
// stage, so they appear without an extra cycle.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready operand handshake (in_ready depends only on output side)
//   op                00 ADD R2+R3, 01 SUB R2-R3, 10 RSUB R3-R2, 11 NEG 0-R3
//   R2, R3            operands A and B
//   out_valid/out_ready result handshake
//   SUB_out           result (modulo 2^word_size)
//   c_out             carry out of MSB (1 = no borrow for subtract forms)
//   overflow          signed overflow
//   zero, negative    result == 0, result MSB
module addsub_pipe_n_bit #(
  parameter int word_size  = 32,
  parameter int num_stages = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [word_size-1:0] R2,
  input  logic [word_size-1:0] R3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [word_size-1:0] SUB_out,
  output logic                 c_out,
  output logic                 overflow,
  output logic                 zero,
  output logic                 negative
);

  localparam int slice_w = word_size / num_stages;

  if (num_stages < 1 || num_stages > word_size || (word_size % num_stages) != 0)
  begin : g_param_check
    $error("addsub_pipe_n_bit: num_stages must be in 1..word_size and divide word_size");
  end

  typedef enum logic [1:0] {
    op_add  = 2'b00,
    op_sub  = 2'b01,
    op_rsub = 2'b10,
    op_neg  = 2'b11
  } op_e;

  logic                 adv;
  logic                 accept;
  logic [word_size-1:0] x0;
  logic [word_size-1:0] y0;
  logic                 cin0;

  // Whole pipeline moves or holds as one; a stalled output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // Every operation is reduced to X + Y + cin.
  always_comb begin
    x0   = R2;
    y0   = R3;
    cin0 = 1'b0;
    case (op_e'(op))
      op_add: begin
        x0   = R2;
        y0   = R3;
        cin0 = 1'b0;
      end
      op_sub: begin
        x0   = R2;
        y0   = ~R3;
        cin0 = 1'b1;
      end
      op_rsub: begin
        x0   = R3;
        y0   = ~R2;
        cin0 = 1'b1;
      end
      op_neg: begin
        x0   = '0;
        y0   = ~R3;
        cin0 = 1'b1;
      end
      default: begin
        x0   = R2;
        y0   = R3;
        cin0 = 1'b0;
      end
    endcase
  end

  for (genvar k = 0; k < num_stages; k++) begin : g_stage
    // in_w: operand bits still pending when the beat enters stage k.
    // out_w: result bits resolved once stage k has registered.
    localparam int in_w  = word_size - k * slice_w;
    localparam int out_w = (k + 1) * slice_w;

    logic [in_w-1:0]    x_i;
    logic [in_w-1:0]    y_i;
    logic               c_i;
    logic               v_i;
    logic [slice_w:0]   slice_sum;
    logic [out_w-1:0]   res_d;
    logic [out_w-1:0]   res_q;
    logic               c_q;
    logic               v_q;

    if (k == 0) begin : g_head
      assign x_i   = x0;
      assign y_i   = y0;
      assign c_i   = cin0;
      assign v_i   = accept;
      assign res_d = slice_sum[slice_w-1:0];
    end else begin : g_body
      assign x_i   = g_stage[k-1].g_fwd.x_q;
      assign y_i   = g_stage[k-1].g_fwd.y_q;
      assign c_i   = g_stage[k-1].c_q;
      assign v_i   = g_stage[k-1].v_q;
      assign res_d = {slice_sum[slice_w-1:0], g_stage[k-1].res_q};
    end

    assign slice_sum = {1'b0, x_i[slice_w-1:0]} + {1'b0, y_i[slice_w-1:0]}
                     + {{slice_w{1'b0}}, c_i};

    // Data registers load only for valid beats so bubbles leave the last
    // delivered result on the outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        res_q <= '0;
        c_q   <= 1'b0;
      end else if (adv) begin
        v_q <= v_i;
        if (v_i) begin
          res_q <= res_d;
          c_q   <= slice_sum[slice_w];
        end
      end
    end

    if (k < num_stages - 1) begin : g_fwd
      logic [in_w-slice_w-1:0] x_q;
      logic [in_w-slice_w-1:0] y_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          x_q <= '0;
          y_q <= '0;
        end else if (adv && v_i) begin
          x_q <= x_i[in_w-1:slice_w];
          y_q <= y_i[in_w-1:slice_w];
        end
      end
    end else begin : g_last
      logic msb_cin;
      logic ovf_q;
      logic zero_q;
      logic neg_q;

      // Carry into the MSB recovered from the MSB sum bit: s = x ^ y ^ cin.
      assign msb_cin = x_i[in_w-1] ^ y_i[in_w-1] ^ slice_sum[slice_w-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
          neg_q  <= 1'b0;
        end else if (adv && v_i) begin
          ovf_q  <= msb_cin ^ slice_sum[slice_w];
          zero_q <= (res_d == '0);
          neg_q  <= res_d[word_size-1];
        end
      end
    end
  end

  assign out_valid = g_stage[num_stages-1].v_q;
  assign SUB_out   = g_stage[num_stages-1].res_q;
  assign c_out     = g_stage[num_stages-1].c_q;
  assign overflow  = g_stage[num_stages-1].g_last.ovf_q;
  assign zero      = g_stage[num_stages-1].g_last.zero_q;
  assign negative  = g_stage[num_stages-1].g_last.neg_q;

endmodule
